// File: rtl/pcileech_sysctl_pkg.sv
// Shared types and constants for the system-control block: LED modes,
// reset-sequencer states and the hold counter width.
package pcileech_sysctl_pkg;

    localparam int SYSCTL_HOLD_W = 16;

    typedef enum logic [1:0] {
        LED_OFF       = 2'b00,
        LED_ON        = 2'b01,
        LED_ACT       = 2'b10,
        LED_HEARTBEAT = 2'b11
    } led_mode_t;

    typedef enum logic {
        S_HOLD = 1'b0,
        S_RUN  = 1'b1
    } rst_state_t;

endpackage

// File: rtl/pcileech_sysctl_ledch.sv
// One LED channel: retriggerable activity stretch counter, mode mux and
// registered LED drive with optional XOR against the power-on blink phase.
module pcileech_sysctl_ledch
    import pcileech_sysctl_pkg::*;
#(
    parameter int STRETCH_BITS = 22
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rst_sys_i,
    input  logic       act_i,
    input  logic [1:0] mode_i,
    input  logic       heartbeat_i,
    input  logic       blink_i,
    output logic       led_o
);

    localparam logic [STRETCH_BITS:0] STRETCH_LOAD = {1'b1, {STRETCH_BITS{1'b0}}};

    logic [STRETCH_BITS:0] stretch_q, stretch_d;
    logic                  led_q, led_d;
    logic                  led_base;

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        stretch_d = stretch_q;
        if (rst_sys_i) begin
            stretch_d = '0;
        end else if (act_i) begin
            stretch_d = STRETCH_LOAD;
        end else if (stretch_q != '0) begin
            stretch_d = stretch_q - 1'b1;
        end
    end

    always_comb begin
        led_base = 1'b0;
        case (led_mode_t'(mode_i))
            LED_OFF:       led_base = 1'b0;
            LED_ON:        led_base = 1'b1;
            LED_ACT:       led_base = (stretch_q != '0);
            LED_HEARTBEAT: led_base = heartbeat_i;
            default:       led_base = 1'b0;
        endcase
        led_d = led_base ^ blink_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stretch_q <= '0;
            led_q     <= 1'b0;
        end else begin
            stretch_q <= stretch_d;
            led_q     <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/pcileech_sysctl.sv
// System control: 64-bit tick counter, held fabric reset sequencer and LED
// manager. Define SYSCTL_PWRON_BLINK_EN to invert all LEDs during the power-on window.
module pcileech_sysctl
    import pcileech_sysctl_pkg::*;
#(
    parameter int NUM_LEDS         = 2,
    parameter int RST_HOLD_CYCLES  = 64,
    parameter int BLINK_BIT        = 24,
    parameter int PWRON_WINDOW_BIT = 27,
    parameter int STRETCH_BITS     = 22
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  soft_rst_req,
    output logic [63:0]           tickcount64,
    output logic                  rst_sys,
    output logic                  ft601_rst_n,
    output logic                  pwron_blink,
    input  logic [2*NUM_LEDS-1:0] led_mode,
    input  logic [NUM_LEDS-1:0]   led_act,
    output logic [NUM_LEDS-1:0]   led_out
);

    localparam logic [SYSCTL_HOLD_W-1:0] HOLD_LAST = SYSCTL_HOLD_W'(RST_HOLD_CYCLES - 1);

    logic [63:0]              tick_q;
    rst_state_t               state_q;
    logic [SYSCTL_HOLD_W-1:0] hold_cnt_q;
    logic                     rst_sys_q;
    logic                     blink_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_q + 64'd1;
        end
    end

    // rst_sys follows the state one cycle late, so the hold spans exactly RST_HOLD_CYCLES outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_HOLD;
            hold_cnt_q <= '0;
            rst_sys_q  <= 1'b1;
        end else begin
            rst_sys_q <= (state_q == S_HOLD);
            case (state_q)
                S_HOLD: begin
                    if (soft_rst_req) begin
                        hold_cnt_q <= '0;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        state_q    <= S_RUN;
                        hold_cnt_q <= '0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    if (soft_rst_req) begin
                        state_q    <= S_HOLD;
                        hold_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q    <= S_HOLD;
                    hold_cnt_q <= '0;
                end
            endcase
        end
    end

`ifdef SYSCTL_PWRON_BLINK_EN
    logic pwron_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwron_q <= 1'b0;
        end else begin
            pwron_q <= tick_q[BLINK_BIT] & (tick_q[63:PWRON_WINDOW_BIT] == '0);
        end
    end

    assign blink_phase = pwron_q;
`else
    assign blink_phase = 1'b0;
`endif

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
        pcileech_sysctl_ledch #(
            .STRETCH_BITS (STRETCH_BITS)
        ) u_ledch (
            .clk         (clk),
            .rst         (rst),
            .rst_sys_i   (rst_sys_q),
            .act_i       (led_act[i]),
            .mode_i      (led_mode[2*i +: 2]),
            .heartbeat_i (tick_q[BLINK_BIT+2]),
            .blink_i     (blink_phase),
            .led_o       (led_out[i])
        );
    end

    assign tickcount64 = tick_q;
    assign rst_sys     = rst_sys_q;
    assign ft601_rst_n = ~rst_sys_q;
    assign pwron_blink = blink_phase;

endmodule

// File: tb/tb_pcileech_sysctl.sv
// Scoreboard bench for pcileech_sysctl: stimulus queues hand-derived expected
// values tagged with a cycle number; a negedge monitor pops and compares them.
module tb_pcileech_sysctl;

    localparam int R = 3;  // posedge count at which rst is released

`ifdef SYSCTL_PWRON_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
`else
    localparam bit BLINK_EN = 1'b0;
`endif

    typedef enum int {SIG_TICK, SIG_RST, SIG_FTN, SIG_BLINK, SIG_LED} sig_e;

    typedef struct {
        int unsigned cyc;
        sig_e        sig;
        logic [63:0] val;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        soft_rst_req = 1'b0;
    logic [63:0] tickcount64;
    logic        rst_sys;
    logic        ft601_rst_n;
    logic        pwron_blink;
    logic [3:0]  led_mode = 4'b0000;
    logic [1:0]  led_act = 2'b00;
    logic [1:0]  led_out;

    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    exp_t        q[$];

    pcileech_sysctl #(
        .NUM_LEDS         (2),
        .RST_HOLD_CYCLES  (64),
        .BLINK_BIT        (2),
        .PWRON_WINDOW_BIT (5),
        .STRETCH_BITS     (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .soft_rst_req (soft_rst_req),
        .tickcount64  (tickcount64),
        .rst_sys      (rst_sys),
        .ft601_rst_n  (ft601_rst_n),
        .pwron_blink  (pwron_blink),
        .led_mode     (led_mode),
        .led_act      (led_act),
        .led_out      (led_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void expect_at(input int unsigned c, input sig_e s,
                                      input logic [63:0] v, input string n);
        int i = 0;
        while (i < q.size() && q[i].cyc <= c) i++;
        q.insert(i, '{c, s, v, n});
    endfunction

    task automatic at_negedge(input int unsigned c);
        do @(negedge clk); while (cyc < c);
    endtask

    // Power-on blink phase for a given tick value (window is tick < 32, BLINK_BIT=2).
    function automatic logic win_blink(input int t);
        return BLINK_EN && (t >= 0) && (t < 32) && (((t >> 2) & 1) == 1);
    endfunction

    initial begin : monitor
        exp_t        e;
        logic [63:0] act;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                if (e.cyc != cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL %s: sample missed at cyc %0d, now %0d", e.name, e.cyc, cyc);
                end else begin
                    case (e.sig)
                        SIG_TICK:  act = tickcount64;
                        SIG_RST:   act = {63'd0, rst_sys};
                        SIG_FTN:   act = {63'd0, ft601_rst_n};
                        SIG_BLINK: act = {63'd0, pwron_blink};
                        default:   act = {62'd0, led_out};
                    endcase
                    check(e.name, act, e.val);
                end
            end
        end
    end

    initial begin : stimulus
        int unsigned m;
        logic        b;

        // Reset state while rst is held.
        expect_at(2, SIG_TICK, 64'd0, "rst_tick");
        expect_at(2, SIG_RST, 64'd1, "rst_rst_sys");
        expect_at(2, SIG_FTN, 64'd0, "rst_ft601_n");
        expect_at(2, SIG_BLINK, 64'd0, "rst_blink");
        expect_at(2, SIG_LED, 64'd0, "rst_led");

        // Reset release timing: 64 cycles of rst_sys, tick starts at 1.
        expect_at(R + 1, SIG_TICK, 64'd1, "tick_first");
        expect_at(R + 100, SIG_TICK, 64'd100, "tick_100");
        expect_at(R + 1, SIG_RST, 64'd1, "hold_first");
        expect_at(R + 64, SIG_RST, 64'd1, "hold_last");
        expect_at(R + 64, SIG_FTN, 64'd0, "ft601_hold_last");
        expect_at(R + 65, SIG_RST, 64'd0, "hold_released");
        expect_at(R + 65, SIG_FTN, 64'd1, "ft601_released");

        // Power-on window with all LEDs OFF.
        for (int k = 1; k <= 40; k++)
            expect_at(R + k, SIG_BLINK, {63'd0, win_blink(k - 1)}, $sformatf("blink_k%0d", k));
        for (int k = 2; k <= 40; k++) begin
            b = win_blink(k - 2);
            expect_at(R + k, SIG_LED, {62'd0, b, b}, $sformatf("pwron_led_k%0d", k));
        end
        expect_at(R + 99, SIG_LED, 64'd0, "off_after_window");

        // LED0 ON, LED1 HEARTBEAT (tick bit 4, one cycle late).
        for (int k = 100; k <= 139; k++)
            expect_at(R + k, SIG_LED, {62'd0, 1'b0 + (((k - 1) >> 4) & 1), 1'b1},
                      $sformatf("hb_on_k%0d", k));

        // Soft reset at tick 200, second request 10 cycles into the hold.
        for (int k = 195; k <= 280; k++)
            expect_at(R + k, SIG_RST, {63'd0, (k >= 202 && k <= 275)}, $sformatf("soft_rst_k%0d", k));
        expect_at(R + 230, SIG_FTN, 64'd0, "soft_ft601_held");
        expect_at(R + 201, SIG_TICK, 64'd201, "soft_tick_201");
        expect_at(R + 250, SIG_TICK, 64'd250, "soft_tick_250");
        expect_at(R + 280, SIG_TICK, 64'd280, "soft_tick_280");

        // Activity stretch with retrigger: high for 10 + 16 cycles.
        for (int k = 290; k <= 335; k++)
            expect_at(R + k, SIG_LED, {62'd0, 1'b0, (k >= 301 && k <= 326)}, $sformatf("act_k%0d", k));

        // Second stretch, interrupted by async reset.
        expect_at(R + 350, SIG_LED, 64'd0, "act2_idle");
        for (int k = 351; k <= 355; k++)
            expect_at(R + k, SIG_LED, 64'd1, $sformatf("act2_k%0d", k));

        at_negedge(R);
        rst = 1'b0;

        at_negedge(R + 99);
        led_mode = {LED_HB_CODE(), 2'b01};

        at_negedge(R + 200);
        soft_rst_req = 1'b1;
        at_negedge(R + 201);
        soft_rst_req = 1'b0;
        at_negedge(R + 210);
        soft_rst_req = 1'b1;
        at_negedge(R + 211);
        soft_rst_req = 1'b0;

        at_negedge(R + 289);
        led_mode = 4'b0010;
        at_negedge(R + 299);
        led_act = 2'b01;
        at_negedge(R + 300);
        led_act = 2'b00;
        at_negedge(R + 309);
        led_act = 2'b01;
        at_negedge(R + 310);
        led_act = 2'b00;

        at_negedge(R + 349);
        led_act = 2'b01;
        at_negedge(R + 350);
        led_act = 2'b00;

        // Async reset between clock edges while LED0 is lit.
        at_negedge(R + 355);
        #2 rst = 1'b1;
        #1;
        check("async_led", {62'd0, led_out}, 64'd0);
        check("async_tick", tickcount64, 64'd0);
        check("async_rst_sys", {63'd0, rst_sys}, 64'd1);
        check("async_ft601", {63'd0, ft601_rst_n}, 64'd0);

        at_negedge(R + 360);
        rst = 1'b0;
        m = cyc;
        expect_at(m + 1, SIG_TICK, 64'd1, "rerun_tick_first");
        expect_at(m + 10, SIG_TICK, 64'd10, "rerun_tick_10");
        expect_at(m + 1, SIG_RST, 64'd1, "rerun_hold_first");
        expect_at(m + 64, SIG_RST, 64'd1, "rerun_hold_last");
        expect_at(m + 65, SIG_RST, 64'd0, "rerun_released");
        expect_at(m + 65, SIG_FTN, 64'd1, "rerun_ft601");

        at_negedge(m + 70);
        check("queue_drained", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic logic [1:0] LED_HB_CODE();
        return 2'b11;
    endfunction

endmodule
